memory_slave_responder: RTL

//  Slave (responder) end of the req/ack memory_interface: services single-word read/write

---
 rtl/memory_slave_responder_pkg.sv | 19 +
 rtl/memory_slave_responder_if.sv | 33 +++
 rtl/memory_slave_responder_sram_array.sv | 50 +++++
 rtl/memory_slave_responder.sv | 111 +++++++++++
 4 files changed

// File: rtl/memory_slave_responder_pkg.sv
// Shared types and constants for the req/ack memory interface slave.
// Contents: FSM state encoding, latency bound, counter width helper.
package mem_if_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      ACK     = 2'd2,
      RELEASE = 2'd3
   } mem_slv_state_t;

   localparam int unsigned MAX_LATENCY = 15;

   // Bits needed to hold any value in 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/memory_slave_responder_if.sv
// Req/ack memory interface with a resolved bidirectional data bus.
// Master side drives req, w_en, addr and write data (wr_data gated by wr_oe).
// Slave side drives ack, busy, addr_err and read data (rd_data gated by rd_oe).
// 'data' is the shared tri-state bus seen by both ends.
interface memory_interface #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned ADDR_WIDTH = 16
);
   logic                  req;
   logic                  w_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_oe;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_oe;
   logic                  ack;
   logic                  busy;
   logic                  addr_err;

   // Slave drive takes priority; the protocol never has both enabled at once.
   wire [DATA_WIDTH-1:0] data;
   assign data = rd_oe ? rd_data : (wr_oe ? wr_data : {DATA_WIDTH{1'bz}});

   modport master (
      output req, w_en, addr, wr_data, wr_oe,
      input  data, ack, busy, addr_err, rd_oe
   );

   modport slave (
      input  req, w_en, addr, data,
      output rd_data, rd_oe, ack, busy, addr_err
   );
endinterface

// File: rtl/memory_slave_responder_sram_array.sv
// MEM_DEPTH x DATA_WIDTH word array: one synchronous read port with registered
// rdata, one synchronous write port. Out-of-range writes are dropped and
// out-of-range reads return zero.
// Ports: clk, reset_n (rdata register only), rd_en/rd_addr/rd_data,
//        wr_en/wr_addr/wr_data, in_range_c (combinational check of rd_addr).
module mem_if_sram_array #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned MEM_DEPTH  = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  in_range_c
);
   localparam int unsigned IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned AW1 = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic                  wr_ok;

   // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH compares correctly.
   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return AW1'(a) < AW1'(MEM_DEPTH);
   endfunction

   assign in_range_c = in_range(rd_addr);
   assign wr_ok      = in_range(wr_addr);

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en && wr_ok) begin
         mem[wr_addr[IW-1:0]] <= wr_data;
      end
   end

   // Registered read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= in_range_c ? mem[rd_addr[IW-1:0]] : '0;
      end
   end
endmodule

// File: rtl/memory_slave_responder.sv
// Slave end of the req/ack memory interface: services single-word reads and
// writes against a local word array with a fixed LATENCY (req sampled -> ack).
// Ports: clk, reset_n (async, active-low), bus (memory_interface.slave).
module memory_slave_responder
   import mem_if_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned MEM_DEPTH  = 1024,
   parameter int unsigned LATENCY    = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   memory_interface.slave   bus
);
   localparam int unsigned CW = cnt_width(MAX_LATENCY);

   if (LATENCY < 1 || LATENCY > MAX_LATENCY ||
       64'(MEM_DEPTH) > (64'(1) << ADDR_WIDTH)) begin : g_param_err
      $fatal(1, "memory_slave_responder: illegal LATENCY or MEM_DEPTH");
   end

   mem_slv_state_t        state, state_d;
   logic [CW-1:0]         cnt, cnt_d;
   logic [ADDR_WIDTH-1:0] cap_addr, cap_addr_d;
   logic                  cap_w_en, cap_w_en_d;
   logic [DATA_WIDTH-1:0] cap_data, cap_data_d;
   logic                  ack_d, busy_d, rd_oe_d, addr_err_d;
   logic [ADDR_WIDTH-1:0] arr_addr_c;
   logic                  in_range_c;
   logic                  wr_en_c;
   logic [DATA_WIDTH-1:0] arr_rdata;

   // Next state, capture and registered-output decode.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      cap_addr_d = cap_addr;
      cap_w_en_d = cap_w_en;
      cap_data_d = cap_data;
      addr_err_d = bus.addr_err;
      case (state)
         IDLE: begin
            if (bus.req) begin
               cap_addr_d = bus.addr;
               cap_w_en_d = bus.w_en;
               cap_data_d = bus.data;
               cnt_d      = CW'(LATENCY - 1);
               state_d    = (LATENCY == 1) ? ACK : WAIT;
               if (!in_range_c) addr_err_d = 1'b1;
            end
         end
         WAIT: begin
            cnt_d = cnt - CW'(1);
            if (cnt == CW'(1)) state_d = ACK;
         end
         ACK:     state_d = RELEASE;
         RELEASE: if (!bus.req) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ack_d   = (state_d == ACK);
      busy_d  = (state_d != IDLE);
      rd_oe_d = (state_d == ACK) && !cap_w_en_d;
   end

   // While idle the array looks at the live bus address so LATENCY==1 reads
   // and the range check see the address being captured this edge.
   assign arr_addr_c  = (state == IDLE) ? bus.addr : cap_addr;
   assign wr_en_c     = (state == ACK) && cap_w_en;
   assign bus.rd_data = arr_rdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         cap_addr     <= '0;
         cap_w_en     <= 1'b0;
         cap_data     <= '0;
         bus.ack      <= 1'b0;
         bus.busy     <= 1'b0;
         bus.rd_oe    <= 1'b0;
         bus.addr_err <= 1'b0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         cap_addr     <= cap_addr_d;
         cap_w_en     <= cap_w_en_d;
         cap_data     <= cap_data_d;
         bus.ack      <= ack_d;
         bus.busy     <= busy_d;
         bus.rd_oe    <= rd_oe_d;
         bus.addr_err <= addr_err_d;
      end
   end

   mem_if_sram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_array (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_en      (rd_oe_d),
      .rd_addr    (arr_addr_c),
      .rd_data    (arr_rdata),
      .wr_en      (wr_en_c),
      .wr_addr    (cap_addr),
      .wr_data    (cap_data),
      .in_range_c (in_range_c)
   );
endmodule
